// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx_pkg
// Description : Shared definitions for the MMIO UART transmitter. This covers
//               bus widths, register offsets, response codes, STATUS bit
//               positions and serializer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_tx_pkg;

   // Bus geometry shared with the host core
   localparam int BUS_WIDTH      = 32;
   localparam int BUS_RESP_WIDTH = 1;

   // Register offsets from the window base address
   localparam logic [31:0] TXDATA_OFFSET  = 32'h0;
   localparam logic [31:0] STATUS_OFFSET  = 32'h4;
   localparam logic [31:0] TXCOUNT_OFFSET = 32'h8;

   // Write response codes
   localparam logic [BUS_RESP_WIDTH-1:0] RESP_OK  = 1'b0;
   localparam logic [BUS_RESP_WIDTH-1:0] RESP_ERR = 1'b1;

   // STATUS register bit positions
   localparam int STATUS_FULL_BIT  = 0;
   localparam int STATUS_EMPTY_BIT = 1;
   localparam int STATUS_BUSY_BIT  = 2;

   // Serializer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // Assemble the STATUS word from its flag bits
   function automatic logic [31:0] status_word(input logic busy,
                                               input logic empty,
                                               input logic full);
      logic [31:0] w;
      w                   = '0;
      w[STATUS_BUSY_BIT]  = busy;
      w[STATUS_EMPTY_BIT] = empty;
      w[STATUS_FULL_BIT]  = full;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with a registered occupancy count. Full and
//               empty are both derived from that count. A push while full
//               or a pop while empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int            AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == FULL_COUNT);
   assign empty_o = (count_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // Occupancy next-state: a simultaneous push and pop leaves it unchanged
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointers and count; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter. It has a TXDATA register
//               that feeds a byte FIFO, a STATUS register, and a serializer
//               FSM driving tx.
//               Define MMIO_UART_TX_COUNT_EN to add the read-only TXCOUNT
//               register, which counts completed stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h8004,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      dr_addr_valid,
   output logic                      dr_addr_ready,
   input  logic [BUS_WIDTH-1:0]      dr_addr,
   output logic                      dr_data_valid,
   input  logic                      dr_data_ready,
   output logic [BUS_WIDTH-1:0]      dr_data,
   input  logic                      dw_data_addr_valid,
   output logic                      dw_data_addr_ready,
   input  logic [BUS_WIDTH-1:0]      dw_addr,
   input  logic [BUS_WIDTH-1:0]      dw_data,
   input  logic [BUS_WIDTH/8-1:0]    dw_strobe,
   output logic                      dw_resp_valid,
   input  logic                      dw_resp_ready,
   output logic [BUS_RESP_WIDTH-1:0] dw_resp,
   output logic                      tx
);

   localparam logic [31:0] ADDR_TXDATA  = BASE_ADDR + TXDATA_OFFSET;
   localparam logic [31:0] ADDR_STATUS  = BASE_ADDR + STATUS_OFFSET;
   localparam logic [31:0] ADDR_TXCOUNT = BASE_ADDR + TXCOUNT_OFFSET;
   localparam logic [15:0] BAUD_LAST    = 16'(CLK_DIV - 1);

   // FIFO interface
   logic       fifo_push;
   logic       fifo_pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_rdata;

   // Bus channel state
   logic                      wr_accept;
   logic                      rd_accept;
   logic                      dw_resp_valid_q;
   logic [BUS_RESP_WIDTH-1:0] dw_resp_q;
   logic                      dr_data_valid_q;
   logic [BUS_WIDTH-1:0]      dr_data_q;
   logic [BUS_WIDTH-1:0]      rd_word;

   // Serializer state
   tx_state_e  state_q;
   logic [15:0] baud_q;
   logic [2:0]  bit_q;
   logic [7:0]  shreg_q;
   logic        tx_q;
   logic        tx_busy;
   logic        baud_done;
   logic        stop_done;

   // Optional TXCOUNT view
   logic        txcount_mapped;
   logic [31:0] txcount_word;

   // Upper data bytes and byte enables have no destination in this block
   logic unused_bus_bits;
   assign unused_bus_bits = ^{dw_data[BUS_WIDTH-1:8], dw_strobe[BUS_WIDTH/8-1:1]};

   // ---------------------------------------------------------------------
   // Bus handshakes. Readies are held low while in reset.
   // ---------------------------------------------------------------------
   assign dw_data_addr_ready = rst & ~dw_resp_valid_q
                             & ~((dw_addr == ADDR_TXDATA) & fifo_full);
   assign dr_addr_ready      = rst & ~dr_data_valid_q;

   assign wr_accept = dw_data_addr_valid & dw_data_addr_ready;
   assign rd_accept = dr_addr_valid & dr_addr_ready;

   // Only strobed-in TXDATA writes reach the FIFO; fullness is already in ready
   assign fifo_push = wr_accept & (dw_addr == ADDR_TXDATA) & dw_strobe[0];

   assign dw_resp_valid = dw_resp_valid_q;
   assign dw_resp       = dw_resp_q;
   assign dr_data_valid = dr_data_valid_q;
   assign dr_data       = dr_data_q;

   // Write response: raised the cycle after acceptance, held until taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dw_resp_valid_q <= 1'b0;
         dw_resp_q       <= RESP_OK;
      end else if (wr_accept) begin
         dw_resp_valid_q <= 1'b1;
         dw_resp_q       <= (dw_addr == ADDR_TXDATA) ? RESP_OK : RESP_ERR;
      end else if (dw_resp_ready) begin
         dw_resp_valid_q <= 1'b0;
      end
   end

   // Read mux: STATUS, optional TXCOUNT, zero everywhere else
   always_comb begin
      rd_word = '0;
      if (dr_addr == ADDR_STATUS) begin
         rd_word = status_word(tx_busy, fifo_empty, fifo_full);
      end else if (txcount_mapped && (dr_addr == ADDR_TXCOUNT)) begin
         rd_word = txcount_word;
      end
   end

   // Read data: captured in the acceptance cycle, held until taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dr_data_valid_q <= 1'b0;
         dr_data_q       <= '0;
      end else if (rd_accept) begin
         dr_data_valid_q <= 1'b1;
         dr_data_q       <= rd_word;
      end else if (dr_data_ready) begin
         dr_data_valid_q <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Byte FIFO
   // ---------------------------------------------------------------------
   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .data_i  (dw_data[7:0]),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // ---------------------------------------------------------------------
   // Serializer
   // ---------------------------------------------------------------------
   assign baud_done = (baud_q == BAUD_LAST);
   assign stop_done = (state_q == ST_STOP) & baud_done;
   assign tx_busy   = (state_q != ST_IDLE);
   assign tx        = tx_q;

   // Pop from IDLE, or at the end of a stop bit so frames run back-to-back
   assign fifo_pop  = ~fifo_empty & ((state_q == ST_IDLE) | stop_done);

   // Frame sequencer with a registered line output
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               baud_q <= '0;
               bit_q  <= '0;
               tx_q   <= 1'b1;
               if (fifo_pop) begin
                  state_q <= ST_START;
                  shreg_q <= fifo_rdata;
                  tx_q    <= 1'b0;
               end
            end
            ST_START: begin
               if (baud_done) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shreg_q[0];
                  shreg_q <= {1'b0, shreg_q[7:1]};
                  state_q <= ST_DATA;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            ST_DATA: begin
               if (baud_done) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     bit_q   <= '0;
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     tx_q    <= shreg_q[0];
                     shreg_q <= {1'b0, shreg_q[7:1]};
                  end
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            ST_STOP: begin
               if (baud_done) begin
                  baud_q <= '0;
                  if (fifo_pop) begin
                     state_q <= ST_START;
                     shreg_q <= fifo_rdata;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= ST_IDLE;
                     tx_q    <= 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               baud_q  <= '0;
               bit_q   <= '0;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Completed-frame counter
   // ---------------------------------------------------------------------
`ifdef MMIO_UART_TX_COUNT_EN
   logic [31:0] txcount_q;

   // Count each finished stop bit; wraps naturally at 2^32
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         txcount_q <= '0;
      end else if (stop_done) begin
         txcount_q <= txcount_q + 32'd1;
      end
   end

   assign txcount_mapped = 1'b1;
   assign txcount_word   = txcount_q;
`else
   logic unused_stop_done;
   assign unused_stop_done = stop_done;
   assign txcount_mapped   = 1'b0;
   assign txcount_word     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Self-checking bench for mmio_uart_tx. It applies a table of
//               register accesses and then runs directed sequences for frame
//               timing, FIFO back-pressure, response stalls, reset
//               mid-frame and the optional frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

   logic        clk;
   logic        rst;
   logic        dr_addr_valid;
   logic        dr_addr_ready;
   logic [31:0] dr_addr;
   logic        dr_data_valid;
   logic        dr_data_ready;
   logic [31:0] dr_data;
   logic        dw_data_addr_valid;
   logic        dw_data_addr_ready;
   logic [31:0] dw_addr;
   logic [31:0] dw_data;
   logic [3:0]  dw_strobe;
   logic        dw_resp_valid;
   logic        dw_resp_ready;
   logic [0:0]  dw_resp;
   logic        tx;

   int n_checks;
   int n_fails;

   mmio_uart_tx #(
      .BASE_ADDR  (32'h8004),
      .CLK_DIV    (4),
      .FIFO_DEPTH (8)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .dr_addr_valid      (dr_addr_valid),
      .dr_addr_ready      (dr_addr_ready),
      .dr_addr            (dr_addr),
      .dr_data_valid      (dr_data_valid),
      .dr_data_ready      (dr_data_ready),
      .dr_data            (dr_data),
      .dw_data_addr_valid (dw_data_addr_valid),
      .dw_data_addr_ready (dw_data_addr_ready),
      .dw_addr            (dw_addr),
      .dw_data            (dw_data),
      .dw_strobe          (dw_strobe),
      .dw_resp_valid      (dw_resp_valid),
      .dw_resp_ready      (dw_resp_ready),
      .dw_resp            (dw_resp),
      .tx                 (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one write; returns the response and the number of stalled cycles
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [0:0] resp, output int stall);
      @(negedge clk);
      dw_data_addr_valid = 1'b1;
      dw_addr            = a;
      dw_data            = d;
      dw_strobe          = s;
      #1;
      stall = 0;
      while (!dw_data_addr_ready && stall < 400) begin
         @(negedge clk);
         #1;
         stall++;
      end
      if (!dw_data_addr_ready) begin
         check("wr_accept_timeout", 32'd0, 32'd1);
         dw_data_addr_valid = 1'b0;
         resp = 'x;
         return;
      end
      @(negedge clk);
      dw_data_addr_valid = 1'b0;
      check("wr_resp_valid_next_cycle", 32'(dw_resp_valid), 32'd1);
      resp = dw_resp;
   endtask

   // Issue one read; returns the data word
   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      int stall;
      @(negedge clk);
      dr_addr_valid = 1'b1;
      dr_addr       = a;
      #1;
      stall = 0;
      while (!dr_addr_ready && stall < 400) begin
         @(negedge clk);
         #1;
         stall++;
      end
      if (!dr_addr_ready) begin
         check("rd_accept_timeout", 32'd0, 32'd1);
         dr_addr_valid = 1'b0;
         d = 'x;
         return;
      end
      @(negedge clk);
      dr_addr_valid = 1'b0;
      check("rd_data_valid_next_cycle", 32'(dr_data_valid), 32'd1);
      d = dr_data;
   endtask

   // Hard stop if something hangs outside a bounded wait
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [0:0]  r;
      logic [31:0] rd;
      logic [9:0]  frame;
      logic [31:0] exp_cnt;
      int          st;

      n_checks = 0;
      n_fails  = 0;

      vecs[0] = '{wr:1'b0, addr:32'h8008, wdata:32'h0,  strb:4'h0, exp:32'h2, name:"rd_status_reset"};
      vecs[1] = '{wr:1'b0, addr:32'h8004, wdata:32'h0,  strb:4'h0, exp:32'h0, name:"rd_txdata_zero"};
      vecs[2] = '{wr:1'b0, addr:32'h8000, wdata:32'h0,  strb:4'h0, exp:32'h0, name:"rd_below_base"};
      vecs[3] = '{wr:1'b0, addr:32'h8010, wdata:32'h0,  strb:4'h0, exp:32'h0, name:"rd_unmapped"};
      vecs[4] = '{wr:1'b0, addr:32'h800C, wdata:32'h0,  strb:4'h0, exp:32'h0, name:"rd_txcount_reset"};
      vecs[5] = '{wr:1'b1, addr:32'h8008, wdata:32'hFF, strb:4'hF, exp:32'h1, name:"wr_status_err"};
      vecs[6] = '{wr:1'b1, addr:32'h8010, wdata:32'h12, strb:4'hF, exp:32'h1, name:"wr_unmapped_err"};
      vecs[7] = '{wr:1'b1, addr:32'h800C, wdata:32'h34, strb:4'hF, exp:32'h1, name:"wr_txcount_err"};
      vecs[8] = '{wr:1'b1, addr:32'h8004, wdata:32'h77, strb:4'hE, exp:32'h0, name:"wr_txdata_nostrobe_ok"};
      vecs[9] = '{wr:1'b0, addr:32'h8008, wdata:32'h0,  strb:4'h0, exp:32'h2, name:"rd_status_no_push"};

      rst                = 1'b0;
      dr_addr_valid      = 1'b0;
      dr_addr            = '0;
      dr_data_ready      = 1'b1;
      dw_data_addr_valid = 1'b0;
      dw_addr            = '0;
      dw_data            = '0;
      dw_strobe          = '0;
      dw_resp_ready      = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx",            32'(tx),                 32'd1);
      check("rst_dr_addr_ready", 32'(dr_addr_ready),      32'd0);
      check("rst_dw_ready",      32'(dw_data_addr_ready), 32'd0);
      check("rst_dr_data_valid", 32'(dr_data_valid),      32'd0);
      check("rst_dr_data",       dr_data,                 32'd0);
      check("rst_dw_resp_valid", 32'(dw_resp_valid),      32'd0);
      check("rst_dw_resp",       32'(dw_resp),            32'd0);
      rst = 1'b1;

      // Register-access table
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].wr) begin
            bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, r, st);
            check(vecs[i].name, 32'(r), vecs[i].exp);
         end else begin
            bus_read(vecs[i].addr, rd);
            check(vecs[i].name, rd, vecs[i].exp);
         end
      end
      check("tx_idle_after_table", 32'(tx), 32'd1);

      // Single 0x41 frame: start, LSB-first data, stop, 4 cycles each
      frame = {1'b1, 8'h41, 1'b0};
      bus_write(32'h8004, 32'h41, 4'hF, r, st);
      check("frame_resp_ok", 32'(r), 32'd0);
      check("frame_tx_before_start", 32'(tx), 32'd1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check($sformatf("frame_bit%0d_cyc%0d", i / 4, i % 4), 32'(tx), 32'(frame[i / 4]));
      end
      @(negedge clk);
      check("frame_tx_idle_after", 32'(tx), 32'd1);
      bus_read(32'h8008, rd);
      check("status_after_frame", rd, 32'h2);

      // STATUS mid-frame with the FIFO drained
      bus_write(32'h8004, 32'h33, 4'hF, r, st);
      repeat (3) @(negedge clk);
      bus_read(32'h8008, rd);
      check("status_busy_empty", rd, 32'h6);
      repeat (60) @(negedge clk);

      // Back-pressure: eight writes fill the FIFO behind a running frame
      bus_write(32'h8004, 32'h55, 4'hF, r, st);
      for (int k = 1; k <= 8; k++) begin
         bus_write(32'h8004, 32'(k), 4'hF, r, st);
         check($sformatf("fill_write%0d_nostall", k), 32'(st), 32'd0);
         check($sformatf("fill_write%0d_ok", k), 32'(r), 32'd0);
      end
      bus_read(32'h8008, rd);
      check("status_busy_full", rd, 32'h5);
      bus_write(32'h8004, 32'h99, 4'hF, r, st);
      check("ninth_write_stalled", 32'(st > 0), 32'd1);
      check("ninth_write_ok", 32'(r), 32'd0);
      repeat (420) @(negedge clk);
      bus_read(32'h8008, rd);
      check("status_after_drain", rd, 32'h2);

      // Held write response to an unmapped address
      dw_resp_ready = 1'b0;
      @(negedge clk);
      dw_data_addr_valid = 1'b1;
      dw_addr            = 32'h8010;
      dw_data            = 32'h99;
      dw_strobe          = 4'hF;
      #1;
      check("stall_wr_ready_initial", 32'(dw_data_addr_ready), 32'd1);
      @(negedge clk);
      dw_data_addr_valid = 1'b0;
      dw_addr            = 32'h8004;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("stall_resp_valid_c%0d", c), 32'(dw_resp_valid),      32'd1);
         check($sformatf("stall_resp_err_c%0d", c),   32'(dw_resp),            32'd1);
         check($sformatf("stall_wr_ready_c%0d", c),   32'(dw_data_addr_ready), 32'd0);
         @(negedge clk);
      end
      dw_resp_ready = 1'b1;
      @(negedge clk);
      #1;
      check("stall_resp_released", 32'(dw_resp_valid),      32'd0);
      check("stall_wr_ready_back", 32'(dw_data_addr_ready), 32'd1);
      check("stall_tx_idle",       32'(tx),                 32'd1);
      bus_read(32'h8008, rd);
      check("stall_status_unchanged", rd, 32'h2);

      // Reset in the middle of the data bits with a byte still queued
      bus_write(32'h8004, 32'hA5, 4'hF, r, st);
      bus_write(32'h8004, 32'h5A, 4'hF, r, st);
      repeat (6) @(negedge clk);
      check("pre_reset_tx_in_data", 32'(dut.state_q == 2'd2), 32'd1);
      rst = 1'b0;
      #1;
      check("mid_reset_tx",       32'(tx),                 32'd1);
      check("mid_reset_dr_ready", 32'(dr_addr_ready),      32'd0);
      check("mid_reset_dw_ready", 32'(dw_data_addr_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_reset_tx", 32'(tx), 32'd1);
      bus_read(32'h8008, rd);
      check("post_reset_status", rd, 32'h2);

      // Three frames, then the frame counter
      for (int k = 0; k < 3; k++) begin
         bus_write(32'h8004, 32'(8'h10 + k), 4'hF, r, st);
      end
      repeat (200) @(negedge clk);
`ifdef MMIO_UART_TX_COUNT_EN
      exp_cnt = 32'd3;
`else
      exp_cnt = 32'd0;
`endif
      bus_read(32'h800C, rd);
      check("txcount_three_frames", rd, exp_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8004, base byte address of the register window.
REQ-002 SHALL have parameter CLK_DIV, default 16, clk cycles per serial bit (legal range 2..65535).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, TX byte FIFO entries (power of two, at least 2).
REQ-004 SHALL have ports, one per line, in this order:
  clk  in  1  sole clock, rising edge
  rst  in  1  reset, asynchronous, active-low
  dr_addr_valid  in  1  read address valid
  dr_addr_ready  out  1  read address accept
  dr_addr  in  BUS_WIDTH  read byte address
  dr_data_valid  out  1  read data valid
  dr_data_ready  in  1  read data accept
  dr_data  out  BUS_WIDTH  read data
  dw_data_addr_valid  in  1  write address+data valid
  dw_data_addr_ready  out  1  write accept
  dw_addr  in  BUS_WIDTH  write byte address
  dw_data  in  BUS_WIDTH  write data
  dw_strobe  in  BUS_WIDTH/8  byte enables
  dw_resp_valid  out  1  write response valid
  dw_resp_ready  in  1  write response accept
  dw_resp  out  BUS_RESP_WIDTH  write response code
  tx  out  1  serial 8N1 line, idle high

Function
REQ-005 SHALL map TXDATA at BASE_ADDR+0 (write-only, byte 0) and STATUS at BASE_ADDR+4 (read-only); all other addresses are unmapped.
REQ-006 SHALL return STATUS = {29'b0, tx_busy, fifo_empty, fifo_full} in bits [2:0].
REQ-007 SHALL transfer on any channel only in a cycle where valid and ready are both high; an initiator's valid is never required to wait on ready.
REQ-008 SHALL drive dw_data_addr_ready high only when dw_resp_valid is low and not (dw_addr==TXDATA and fifo_full).
REQ-009 SHALL, on a write accepted to TXDATA with dw_strobe[0]=1, push dw_data[7:0] into the FIFO; with dw_strobe[0]=0, push nothing; both cases respond RESP_OK.
REQ-010 SHALL respond RESP_ERR to writes to STATUS or unmapped addresses, with no side effect.
REQ-011 SHALL assert dw_resp_valid exactly one cycle after write acceptance and hold it and dw_resp stable until dw_resp_ready is sampled high.
REQ-012 SHALL drive dr_addr_ready high only when dr_data_valid is low; dr_data_valid asserts one cycle after acceptance and holds, with dr_data stable, until dr_data_ready is sampled high.
REQ-013 SHALL return 0 on reads of TXDATA or unmapped addresses; STATUS is sampled in the acceptance cycle.
REQ-014 SHALL run serializer FSM IDLE->START->DATA->STOP->IDLE; IDLE pops the FIFO when non-empty; START drives 0, DATA drives 8 bits LSB first, STOP drives 1, each for exactly CLK_DIV cycles; tx=1 in IDLE.
REQ-015 SHALL start the start bit in the cycle after the pop; STOP goes directly to START when the FIFO is non-empty (back-to-back frames, no idle gap).
REQ-016 SHALL report tx_busy=1 whenever the FSM is not IDLE.
REQ-017 SHALL judge fullness on the registered count: a push in a full cycle is stalled even if a pop occurs in that cycle; simultaneous push and pop in a non-full cycle leaves count unchanged.
REQ-018 SHALL allow a write to TXDATA into an empty FIFO with an idle FSM to reach tx (start bit) 2 cycles after acceptance.

Reset
REQ-019 SHALL, while rst=0, force: tx=1, FSM=IDLE, FIFO empty, baud and bit counters 0, dr_data_valid=0, dr_data=0, dw_resp_valid=0, dw_resp=RESP_OK, dr_addr_ready=0, dw_data_addr_ready=0; a frame in progress is abandoned.

Configuration
REQ-020 SHALL, with MMIO_UART_TX_COUNT_EN defined, map read-only TXCOUNT at BASE_ADDR+8: a 32-bit count of completed stop bits, reset to 0, wrapping 32'hFFFFFFFF->0; writes to it return RESP_ERR.
REQ-021 SHALL, without MMIO_UART_TX_COUNT_EN, have no counter; BASE_ADDR+8 is unmapped.

Structure
REQ-022 SHALL take BUS_WIDTH and BUS_RESP_WIDTH from copperv_h.v, and define register offsets, RESP_OK/RESP_ERR codes and STATUS bit indices in a shared header mmio_uart_h.v.
REQ-023 SHALL instantiate the byte FIFO as sub-module sync_fifo (push/pop/full/empty, registered count).

Verification
REQ-024 CLK_DIV=4, write 32'h41 to 32'h8004 with strobe 4'hF -> RESP_OK next cycle; tx shows 0, then 1,0,0,0,0,0,1,0, then 1, each bit 4 cycles.
REQ-025 Nine back-to-back TXDATA writes while the first frame transmits -> writes 1..8 accepted, 9th sees dw_data_addr_ready=0 until the next pop, then accepted.
REQ-026 Read 32'h8008 after reset -> dr_data=32'h00000002; during a frame with FIFO empty -> 32'h00000006.
REQ-027 Write 32'h8010 -> RESP_ERR, FIFO count unchanged, tx stays 1.
REQ-028 Hold dw_resp_ready=0 for 3 cycles -> dw_resp_valid and dw_resp stable, dw_data_addr_ready=0 throughout.
REQ-029 Assert rst=0 mid-DATA -> tx=1 and STATUS=32'h2 immediately after release; with MMIO_UART_TX_COUNT_EN, 3 frames then read 32'h800C -> 32'd3.
